// File: rtl/step_pkg.sv
// Shared encodings for the execute-step family: flag op codes and step FSM states.
package step_pkg;

  localparam logic [1:0] OP_CLR = 2'b00;
  localparam logic [1:0] OP_SET = 2'b01;
  localparam logic [1:0] OP_TGL = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

endpackage

// File: rtl/flag_bitop.sv
// Single-bit flag operation: clear/set/toggle one selected bit, reporting write intent.
module flag_bitop
  import step_pkg::*;
#(
  parameter int unsigned FL_WIDTH = 8
) (
  input  logic [FL_WIDTH-1:0]         fl_q,
  input  logic [1:0]                  op,
  input  logic [$clog2(FL_WIDTH)-1:0] bit_sel,
  output logic [FL_WIDTH-1:0]         fl_new,
  output logic                        wr
);

  logic [FL_WIDTH-1:0] mask;
  logic                in_range;

  // Out-of-range selects (non power-of-2 widths) degrade to a nop.
  always_comb begin
    in_range = 32'(bit_sel) < FL_WIDTH;
    mask     = FL_WIDTH'(1) << bit_sel;
    fl_new   = fl_q;
    wr       = 1'b0;
    if (in_range) begin
      case (op)
        OP_CLR: begin
          fl_new = fl_q & ~mask;
          wr     = 1'b1;
        end
        OP_SET: begin
          fl_new = fl_q | mask;
          wr     = 1'b1;
        end
        OP_TGL: begin
          fl_new = fl_q ^ mask;
          wr     = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/step_ex_flagop.sv
// Execute step: read flag register, apply a single-bit op, write back over the shared tri-state buses.
module step_ex_flagop
  import step_pkg::*;
#(
  parameter int unsigned FL_WIDTH  = 8,
  parameter int unsigned READ_WAIT = 0
) (
  input  logic                        clk,
  input  logic                        rst_,
  input  logic                        ena_,
  input  logic [1:0]                  op,
  input  logic [$clog2(FL_WIDTH)-1:0] bit_sel,
  output logic                        rdy_,
  output logic [FL_WIDTH-1:0]         fl_din,
  input  logic [FL_WIDTH-1:0]         fl_dout,
  output logic                        fl_we_
);

  localparam int unsigned SEL_W = $clog2(FL_WIDTH);

  state_t              state, state_nx;
  logic [CNT_W-1:0]    cnt, cnt_nx;
  logic [1:0]          op_q, op_nx;
  logic [SEL_W-1:0]    sel_q, sel_nx;
  logic [FL_WIDTH-1:0] fl_q, fl_nx;
  logic [FL_WIDTH-1:0] fl_new;
  logic                wr;
  logic                rdy_en, din_en, we_en;

  flag_bitop #(.FL_WIDTH(FL_WIDTH)) u_bitop (
    .fl_q    (fl_q),
    .op      (op_q),
    .bit_sel (sel_q),
    .fl_new  (fl_new),
    .wr      (wr)
  );

  // Next-state: issue in IDLE only, wait out READ_WAIT, capture, one WRITE cycle.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    op_nx    = op_q;
    sel_nx   = sel_q;
    fl_nx    = fl_q;
    case (state)
      ST_IDLE: begin
        if (!ena_) begin
          state_nx = ST_READ;
          cnt_nx   = CNT_W'(READ_WAIT);
          op_nx    = op;
          sel_nx   = bit_sel;
        end
      end
      ST_READ: begin
        if (cnt != '0) begin
          cnt_nx = cnt - CNT_W'(1);
        end else begin
          fl_nx    = fl_dout;
          state_nx = ST_WRITE;
        end
      end
      ST_WRITE: state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Output enables are registered off the next state so the buses switch cleanly on the edge.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      op_q   <= '0;
      sel_q  <= '0;
      fl_q   <= '0;
      rdy_en <= 1'b0;
      din_en <= 1'b0;
      we_en  <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      op_q   <= op_nx;
      sel_q  <= sel_nx;
      fl_q   <= fl_nx;
      rdy_en <= (state_nx == ST_WRITE);
      din_en <= (state_nx == ST_WRITE);
      we_en  <= (state_nx == ST_WRITE) && wr;
    end
  end

  assign rdy_   = rdy_en ? 1'b0 : 1'bz;
  assign fl_din = din_en ? fl_new : {FL_WIDTH{1'bz}};
  assign fl_we_ = we_en ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_step_ex_flagop.sv
// Bench for step_ex_flagop: W=0/W=3 at 8 bits and a 6-bit instance, with bus pull-ups so Z reads as 1.
module tb_step_ex_flagop;
  import step_pkg::*;

  logic       clk = 1'b0;
  logic       rst_;
  logic [1:0] op;
  logic [2:0] bit_sel;
  logic       ena_a, ena_b, ena_c;
  logic [7:0] dout_a, dout_b;
  logic [5:0] dout_c;

  wire       rdy_a, we_a, rdy_b, we_b, rdy_c, we_c;
  wire [7:0] din_a, din_b;
  wire [5:0] din_c;

  int checks   = 0;
  int failures = 0;
  int pulses_a = 0;
  int pulses_b = 0;
  int pulses_c = 0;

  always #5 clk = ~clk;

  pullup (rdy_a);
  pullup (we_a);
  pullup (rdy_b);
  pullup (we_b);
  pullup (rdy_c);
  pullup (we_c);
  for (genvar i = 0; i < 8; i++) begin : g_pu8
    pullup (din_a[i]);
    pullup (din_b[i]);
  end
  for (genvar i = 0; i < 6; i++) begin : g_pu6
    pullup (din_c[i]);
  end

  step_ex_flagop #(.FL_WIDTH(8), .READ_WAIT(0)) u_a (
    .clk(clk), .rst_(rst_), .ena_(ena_a), .op(op), .bit_sel(bit_sel),
    .rdy_(rdy_a), .fl_din(din_a), .fl_dout(dout_a), .fl_we_(we_a));

  step_ex_flagop #(.FL_WIDTH(8), .READ_WAIT(3)) u_b (
    .clk(clk), .rst_(rst_), .ena_(ena_b), .op(op), .bit_sel(bit_sel),
    .rdy_(rdy_b), .fl_din(din_b), .fl_dout(dout_b), .fl_we_(we_b));

  step_ex_flagop #(.FL_WIDTH(6), .READ_WAIT(0)) u_c (
    .clk(clk), .rst_(rst_), .ena_(ena_c), .op(op), .bit_sel(bit_sel),
    .rdy_(rdy_c), .fl_din(din_c), .fl_dout(dout_c), .fl_we_(we_c));

  always @(negedge clk) begin
    if (rdy_a === 1'b0) pulses_a++;
    if (rdy_b === 1'b0) pulses_b++;
    if (rdy_c === 1'b0) pulses_c++;
  end

  typedef struct {
    string      name;
    logic [1:0] op;
    logic [2:0] sel;
    logic [7:0] dout;
    logic [7:0] exp_din;
    logic       exp_we;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    int base;
    vecs[0] = '{"tgl0_a5",  OP_TGL, 3'd0, 8'hA5, 8'hA4, 1'b0};
    vecs[1] = '{"clr3_ff",  OP_CLR, 3'd3, 8'hFF, 8'hF7, 1'b0};
    vecs[2] = '{"nop3_ff",  OP_NOP, 3'd3, 8'hFF, 8'hFF, 1'b1};
    vecs[3] = '{"set4_00",  OP_SET, 3'd4, 8'h00, 8'h10, 1'b0};
    vecs[4] = '{"tgl7_80",  OP_TGL, 3'd7, 8'h80, 8'h00, 1'b0};
    vecs[5] = '{"clr0_01",  OP_CLR, 3'd0, 8'h01, 8'h00, 1'b0};
    vecs[6] = '{"set2_04",  OP_SET, 3'd2, 8'h04, 8'h04, 1'b0};

    rst_ = 1'b0; ena_a = 1'b1; ena_b = 1'b1; ena_c = 1'b1;
    op = OP_NOP; bit_sel = '0; dout_a = '0; dout_b = '0; dout_c = '0;

    // Reset: every bus released
    repeat (2) @(negedge clk);
    chk("rst_rdy_a", 32'(rdy_a), 32'h1);
    chk("rst_we_a",  32'(we_a),  32'h1);
    chk("rst_din_a", 32'(din_a), 32'hFF);
    chk("rst_rdy_b", 32'(rdy_b), 32'h1);
    chk("rst_din_b", 32'(din_b), 32'hFF);
    chk("rst_din_c", 32'(din_c), 32'h3F);
    rst_ = 1'b1;
    @(negedge clk);

    // Table-driven single ops on the W=0 instance
    for (int i = 0; i < 7; i++) begin
      ena_a = 1'b0; op = vecs[i].op; bit_sel = vecs[i].sel; dout_a = vecs[i].dout;
      @(negedge clk);
      ena_a = 1'b1;
      chk({vecs[i].name, "_read_rdy"}, 32'(rdy_a), 32'h1);
      @(negedge clk);
      chk({vecs[i].name, "_rdy"}, 32'(rdy_a), 32'h0);
      chk({vecs[i].name, "_din"}, 32'(din_a), 32'(vecs[i].exp_din));
      chk({vecs[i].name, "_we"},  32'(we_a),  32'(vecs[i].exp_we));
      @(negedge clk);
      chk({vecs[i].name, "_rel_rdy"}, 32'(rdy_a), 32'h1);
      chk({vecs[i].name, "_rel_we"},  32'(we_a),  32'h1);
      chk({vecs[i].name, "_rel_din"}, 32'(din_a), 32'hFF);
    end

    // W=3: set bit 7 with a spurious ena_ during READ, fl_dout changed after capture
    base = pulses_b;
    ena_b = 1'b0; op = OP_SET; bit_sel = 3'd7; dout_b = 8'h00;
    @(negedge clk); ena_b = 1'b1;
    @(negedge clk); ena_b = 1'b0;
    @(negedge clk); ena_b = 1'b1;
    chk("w3_e2_rdy", 32'(rdy_b), 32'h1);
    @(negedge clk);
    chk("w3_e3_rdy", 32'(rdy_b), 32'h1);
    @(negedge clk);
    dout_b = 8'hFF;
    #1;
    chk("w3_rdy", 32'(rdy_b), 32'h0);
    chk("w3_din", 32'(din_b), 32'h80);
    chk("w3_we",  32'(we_b),  32'h0);
    @(negedge clk);
    chk("w3_rel_rdy", 32'(rdy_b), 32'h1);
    repeat (6) @(negedge clk);
    #1;
    chk("w3_single_pulse", 32'(pulses_b - base), 32'd1);

    // W=3: latest fl_dout before the capture edge is used
    ena_b = 1'b0; op = OP_TGL; bit_sel = 3'd0; dout_b = 8'hF0;
    @(negedge clk); ena_b = 1'b1;
    @(negedge clk);
    @(negedge clk); dout_b = 8'h0F;
    @(negedge clk); dout_b = 8'h3C;
    @(negedge clk);
    chk("w3cap_rdy", 32'(rdy_b), 32'h0);
    chk("w3cap_din", 32'(din_b), 32'h3D);
    @(negedge clk);

    // Reset in READ: released at once, no later pulse
    base = pulses_b;
    ena_b = 1'b0; op = OP_SET; bit_sel = 3'd0; dout_b = 8'h00;
    @(negedge clk); ena_b = 1'b1;
    @(negedge clk);
    rst_ = 1'b0;
    #1;
    chk("rstrd_rdy", 32'(rdy_b), 32'h1);
    chk("rstrd_we",  32'(we_b),  32'h1);
    @(negedge clk); rst_ = 1'b1;
    repeat (8) @(negedge clk);
    #1;
    chk("rstrd_no_pulse", 32'(pulses_b - base), 32'd0);

    // Reset in WRITE: buses release asynchronously
    ena_a = 1'b0; op = OP_TGL; bit_sel = 3'd0; dout_a = 8'hA5;
    @(negedge clk); ena_a = 1'b1;
    @(negedge clk);
    chk("rstwr_pre_rdy", 32'(rdy_a), 32'h0);
    rst_ = 1'b0;
    #1;
    chk("rstwr_rdy", 32'(rdy_a), 32'h1);
    chk("rstwr_we",  32'(we_a),  32'h1);
    chk("rstwr_din", 32'(din_a), 32'hFF);
    @(negedge clk); rst_ = 1'b1;
    @(negedge clk);

    // 6-bit instance: out-of-range select is a nop, in-range set writes
    ena_c = 1'b0; op = OP_SET; bit_sel = 3'd7; dout_c = 6'h00;
    @(negedge clk); ena_c = 1'b1;
    @(negedge clk);
    chk("w6_oor_rdy", 32'(rdy_c), 32'h0);
    chk("w6_oor_we",  32'(we_c),  32'h1);
    chk("w6_oor_din", 32'(din_c), 32'h00);
    @(negedge clk);
    ena_c = 1'b0; op = OP_SET; bit_sel = 3'd5; dout_c = 6'h00;
    @(negedge clk); ena_c = 1'b1;
    @(negedge clk);
    chk("w6_set5_din", 32'(din_c), 32'h20);
    chk("w6_set5_we",  32'(we_c),  32'h0);
    @(negedge clk);

    // ena_ held low through WRITE: second op issues on the first IDLE edge
    base = pulses_a;
    ena_a = 1'b0; op = OP_TGL; bit_sel = 3'd1; dout_a = 8'h00;
    @(negedge clk);
    @(negedge clk);
    chk("b2b_first_din", 32'(din_a), 32'h02);
    op = OP_SET; bit_sel = 3'd6;
    @(negedge clk);
    chk("b2b_idle_rdy", 32'(rdy_a), 32'h1);
    @(negedge clk); ena_a = 1'b1;
    chk("b2b_read_rdy", 32'(rdy_a), 32'h1);
    @(negedge clk);
    chk("b2b_second_rdy", 32'(rdy_a), 32'h0);
    chk("b2b_second_din", 32'(din_a), 32'h40);
    chk("b2b_second_we",  32'(we_a),  32'h0);
    repeat (4) @(negedge clk);
    #1;
    chk("b2b_pulses", 32'(pulses_a - base), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
